// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop driver: excitation codes, FSM states
// and the helper that picks the J/K pair for a wanted q transition.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Returns {J,K} that takes a flop currently at q to target t.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle);
    logic [1:0] code;
    code = JK_HOLD;
    if (q != t) begin
      if (toggle) begin
        code = JK_TOGGLE;
      end else if (t) begin
        code = JK_SET;
      end else begin
        code = JK_RESET;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_fb_checker.sv
// Feedback checker: delays the issued bit's valid/q_model by one stage so that
// q_fb is compared after the flop has taken the excitation; sticky err.
module jk_fb_checker
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic q_model,
  input  logic q_fb,
  input  logic err_clr,
  output logic err
);

  logic chk_v_q, chk_v_d;
  logic chk_q_q, chk_q_d;
  logic err_q, err_d;
  logic mismatch;

  assign mismatch = chk_v_q && (q_fb != chk_q_q);

  always_comb begin
    chk_v_d = bit_valid;
    chk_q_d = q_model;
    err_d   = err_q;
    // A mismatch in the same cycle as a clear must not be lost.
    if (mismatch) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_v_q <= 1'b0;
      chk_q_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      chk_v_q <= chk_v_d;
      chk_q_q <= chk_q_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/jk_ff_driver.sv
// Write side of a JK flip-flop interface: serialises WIDTH-bit target words
// LSB-first into registered J/K excitations and checks the flop's q feedback.
module jk_ff_driver
  import jk_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit EXCITE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy,
  input  logic             q_fb,
  output logic             q_model,
  input  logic             err_clr,
  output logic             err
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_done_q, word_done_d;
  logic             q_model_q, q_model_d;
  logic [1:0]       jk_code;
  logic             last_bit;
  logic             accept;

  // Handshake: a word transfers on any rising edge where in_valid && in_ready;
  // in_ready is combinational from state/cnt only and never looks at in_valid.
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign in_ready = (state_q == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;
  assign jk_code  = jk_excite(q_model_q, sh_q[0], EXCITE_TOGGLE);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    j_d         = 1'b0;
    k_d         = 1'b0;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;
    q_model_d   = q_model_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {j_d, k_d}  = jk_code;
        bit_valid_d = 1'b1;
        word_done_d = last_bit;
        q_model_d   = sh_q[0];
        if (last_bit) begin
          // Reloading here keeps bit_valid continuous across words.
          if (accept) begin
            sh_d  = in_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      q_model_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
      q_model_q   <= q_model_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign bit_valid = bit_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != IDLE);
  assign q_model   = q_model_q;

  jk_fb_checker u_fb_checker (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid_q),
    .q_model   (q_model_q),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .err       (err)
  );

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: set/reset and toggle variants side by side, each
// driving a behavioural JK flop whose q feeds back to the driver.
module tb_jk_ff_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         err_clr;
  logic         stuck;

  logic in_ready0, j0, k0, bv0, wd0, busy0, qfb0, qm0, err0, fq0;
  logic in_ready1, j1, k1, bv1, wd1, busy1, qfb1, qm1, err1, fq1;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {j, k, word_done, q_model}
  logic [3:0] exp0_q[$];
  logic [3:0] exp1_q[$];
  logic       mq0, mq1;

  int          bv_cnt = 0, bv_starts = 0, wd_cnt = 0, rb_cnt = 0, jk_nz_cnt = 0, qhigh_cnt = 0;
  logic        prev_bv0 = 1'b0, prev_bv1 = 1'b0;
  logic [15:0] seq0 = '0, seq1 = '0;
  logic [7:0]  fseq1 = '0;

  always #5 clk = ~clk;

  jk_ff_driver #(.WIDTH(W), .EXCITE_TOGGLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .j(j0), .k(k0), .bit_valid(bv0), .word_done(wd0), .busy(busy0),
    .q_fb(qfb0), .q_model(qm0), .err_clr(err_clr), .err(err0)
  );

  jk_ff_driver #(.WIDTH(W), .EXCITE_TOGGLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .j(j1), .k(k1), .bit_valid(bv1), .word_done(wd1), .busy(busy1),
    .q_fb(qfb1), .q_model(qm1), .err_clr(err_clr), .err(err1)
  );

  // Behavioural JK flops sharing the driver reset
  always @(posedge clk or posedge rst) begin
    if (rst) fq0 <= 1'b0;
    else case ({j0, k0})
      2'b01:   fq0 <= 1'b0;
      2'b10:   fq0 <= 1'b1;
      2'b11:   fq0 <= ~fq0;
      default: fq0 <= fq0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) fq1 <= 1'b0;
    else case ({j1, k1})
      2'b01:   fq1 <= 1'b0;
      2'b10:   fq1 <= 1'b1;
      2'b11:   fq1 <= ~fq1;
      default: fq1 <= fq1;
    endcase
  end

  assign qfb0 = stuck ? 1'b0 : fq0;
  assign qfb1 = stuck ? 1'b0 : fq1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_jk(input logic q, input logic t, input logic tog);
    if (q == t) return 2'b00;
    if (tog) return 2'b11;
    return {t, ~t};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents d and waits for acceptance; call only just after a posedge.
  task automatic send_word(input logic [W-1:0] d, input bit keep_valid);
    int n;
    logic t;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready0 && n < 100) begin
      cycle();
      n++;
    end
    if (n >= 100) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < W; i++) begin
      t = d[i];
      exp0_q.push_back({model_jk(mq0, t, 1'b0), (i == W - 1), t});
      exp1_q.push_back({model_jk(mq1, t, 1'b1), (i == W - 1), t});
      mq0 = t;
      mq1 = t;
    end
    cycle();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || bv0) && n < 100) begin
      cycle();
      n++;
    end
    check("idle_reached", 32'({busy0, bv0}), 0);
    cycle();
    cycle();
  endtask

  // Monitor: pops the scoreboard on every issued bit and keeps activity counters
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_bv0 = 1'b0;
        prev_bv1 = 1'b0;
      end else begin
        if (bv0) begin
          if (exp0_q.size() == 0) check("sb0_unexpected", 1, 0);
          else begin
            check("sb0_bit", 32'({j0, k0, wd0, qm0}), 32'(exp0_q[0]));
            void'(exp0_q.pop_front());
          end
          bv_cnt++;
          if (!prev_bv0) bv_starts++;
          if (j0 || k0) jk_nz_cnt++;
          seq0 = {seq0[13:0], j0, k0};
        end
        if (bv1) begin
          if (exp1_q.size() == 0) check("sb1_unexpected", 1, 0);
          else begin
            check("sb1_bit", 32'({j1, k1, wd1, qm1}), 32'(exp1_q[0]));
            void'(exp1_q.pop_front());
          end
          if (j1 || k1) jk_nz_cnt++;
          seq1 = {seq1[13:0], j1, k1};
        end
        if (prev_bv1) fseq1 = {fseq1[6:0], qfb1};
        if (wd0) wd_cnt++;
        if (in_ready0 && busy0) rb_cnt++;
        if (qfb0) qhigh_cnt++;
        prev_bv0 = bv0;
        prev_bv1 = bv1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_bv, b_st, b_wd, b_rb, b_jk, b_qh;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0; stuck = 1'b0;
    mq0 = 1'b0; mq1 = 1'b0;
    repeat (3) cycle();

    // Reset state
    check("rst_ready0", 32'(in_ready0), 1);
    check("rst_ready1", 32'(in_ready1), 1);
    check("rst_outs0", 32'({j0, k0, bv0, wd0, busy0, qm0, err0}), 0);
    check("rst_outs1", 32'({j1, k1, bv1, wd1, busy1, qm1, err1}), 0);
    rst = 1'b0;
    cycle();

    // Word A6 from reset on both excitation styles
    b_bv = bv_cnt; b_st = bv_starts; b_wd = wd_cnt;
    send_word(8'hA6, 1'b0);
    wait_idle();
    check("a6_jk_setreset", 32'(seq0), 32'h2126);
    check("a6_jk_toggle", 32'(seq1), 32'h333F);
    check("a6_flop_track", 32'(fseq1), 32'h65);
    check("a6_bits", bv_cnt - b_bv, 8);
    check("a6_word_done", wd_cnt - b_wd, 1);
    check("a6_err", 32'({err0, err1}), 0);

    // Two words streamed with in_valid held
    b_bv = bv_cnt; b_st = bv_starts; b_wd = wd_cnt; b_rb = rb_cnt;
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b0);
    wait_idle();
    check("stream_bits", bv_cnt - b_bv, 16);
    check("stream_no_gap", bv_starts - b_st, 1);
    check("stream_word_done", wd_cnt - b_wd, 2);
    check("stream_ready_in_shift", rb_cnt - b_rb, 2);
    check("stream_err", 32'({err0, err1}), 0);

    // Flop stuck at 0: err timing, clear, and set-beats-clear
    stuck = 1'b1;
    send_word(8'h01, 1'b0);
    cycle();
    check("stuck_err_e1", 32'(err0), 0);
    cycle();
    check("stuck_err_e2", 32'(err0), 0);
    cycle();
    check("stuck_err_e3_0", 32'(err0), 1);
    check("stuck_err_e3_1", 32'(err1), 1);
    wait_idle();
    check("stuck_err_sticky", 32'(err0), 1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("err_cleared", 32'({err0, err1}), 0);
    send_word(8'h01, 1'b0);
    cycle();
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("set_beats_clr0", 32'(err0), 1);
    check("set_beats_clr1", 32'(err1), 1);
    wait_idle();
    stuck = 1'b0;

    // Reset after 3 bits of FF
    send_word(8'hFF, 1'b0);
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check("midrst_outs0", 32'({j0, k0, bv0, qm0, busy0, err0}), 0);
    check("midrst_outs1", 32'({j1, k1, bv1, qm1, busy1, err1}), 0);
    check("midrst_ready", 32'({in_ready0, in_ready1}), 3);
    exp0_q.delete();
    exp1_q.delete();
    mq0 = 1'b0;
    mq1 = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    b_bv = bv_cnt;
    send_word(8'h05, 1'b0);
    wait_idle();
    check("after_rst_bits", bv_cnt - b_bv, 8);
    check("after_rst_err", 32'({err0, err1}), 0);

    // Word 00 from reset: all holds
    rst = 1'b1;
    mq0 = 1'b0;
    mq1 = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    b_bv = bv_cnt; b_jk = jk_nz_cnt; b_qh = qhigh_cnt;
    send_word(8'h00, 1'b0);
    wait_idle();
    check("zero_bits", bv_cnt - b_bv, 8);
    check("zero_jk_hold", jk_nz_cnt - b_jk, 0);
    check("zero_q_low", qhigh_cnt - b_qh, 0);
    check("zero_busy", 32'({busy0, busy1}), 0);
    check("zero_err", 32'({err0, err1}), 0);

    check("sb0_drained", exp0_q.size(), 0);
    check("sb1_drained", exp1_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
